// File: rtl/instruction_encoder.sv
// instruction_encoder
//   Encodes one RV32I operation plus its operand fields into a 32-bit
//   instruction word. It then streams that word out as four bytes, least
//   significant byte first. The program loader and the self-test path use it
//   to write instruction memory over an 8-bit IO.
//
// Configuration macro:
//   ENCODER_RANGE_CHECK_EN - when defined, an immediate that does not fit its
//                            format is rejected with an error pulse. When
//                            undefined, out-of-range immediate bits are
//                            silently truncated.
//
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready - request handshake (ready only while idle)
//   operation, rd, rs1, rs2, immediate - the request fields
//   byte_valid/byte_ready/out_byte     - byte stream, LSB first
//   instruction_word  - last successfully encoded word
//   error             - one-cycle pulse when a request cannot be encoded
//   encoded_count     - number of words fully streamed out (wraps)

package instruction_encoder_pkg;
  typedef enum logic [5:0] {
    invalid,
    lui, auipc, jal, jalr,
    beq, bne, blt, bge, bltu, bgeu,
    lb, lh, lw, lbu, lhu,
    sb, sh, sw,
    addi, slti, xori, ori, andi,
    slli, srli, srai,
    add, sub, sll, slt, xor_, srl, sra, or_, and_
  } operation_t;
endpackage

module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  operation_t             operation,
  input  logic [4:0]             rd,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [31:0]            immediate,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic [7:0]             out_byte,
  output logic [31:0]            instruction_word,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] encoded_count
);

  typedef enum logic {IDLE, SEND} state_t;
  typedef enum logic [2:0] {FMT_NONE, FMT_U, FMT_J, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_R} fmt_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  state_t      state;
  logic [1:0]  byte_idx;

  fmt_t        fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] enc_word;
  logic        range_ok;
  logic        enc_ok;

  // Combinational encoder: classify the operation, then assemble the fields.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    fmt      = FMT_NONE;
    opc      = '0;
    f3       = '0;
    f7       = '0;
    enc_word = '0;
    range_ok = 1'b1;

    case (operation)
      lui:   begin fmt = FMT_U;  opc = OP_LUI;    end
      auipc: begin fmt = FMT_U;  opc = OP_AUIPC;  end
      jal:   begin fmt = FMT_J;  opc = OP_JAL;    end
      jalr:  begin fmt = FMT_I;  opc = OP_JALR;   f3 = 3'b000; end
      lb:    begin fmt = FMT_I;  opc = OP_LOAD;   f3 = 3'b000; end
      lh:    begin fmt = FMT_I;  opc = OP_LOAD;   f3 = 3'b001; end
      lw:    begin fmt = FMT_I;  opc = OP_LOAD;   f3 = 3'b010; end
      lbu:   begin fmt = FMT_I;  opc = OP_LOAD;   f3 = 3'b100; end
      lhu:   begin fmt = FMT_I;  opc = OP_LOAD;   f3 = 3'b101; end
      addi:  begin fmt = FMT_I;  opc = OP_ALUI;   f3 = 3'b000; end
      slti:  begin fmt = FMT_I;  opc = OP_ALUI;   f3 = 3'b010; end
      xori:  begin fmt = FMT_I;  opc = OP_ALUI;   f3 = 3'b100; end
      ori:   begin fmt = FMT_I;  opc = OP_ALUI;   f3 = 3'b110; end
      andi:  begin fmt = FMT_I;  opc = OP_ALUI;   f3 = 3'b111; end
      slli:  begin fmt = FMT_SH; opc = OP_ALUI;   f3 = 3'b001; end
      srli:  begin fmt = FMT_SH; opc = OP_ALUI;   f3 = 3'b101; end
      srai:  begin fmt = FMT_SH; opc = OP_ALUI;   f3 = 3'b101; f7 = F7_ALT; end
      sb:    begin fmt = FMT_S;  opc = OP_STORE;  f3 = 3'b000; end
      sh:    begin fmt = FMT_S;  opc = OP_STORE;  f3 = 3'b001; end
      sw:    begin fmt = FMT_S;  opc = OP_STORE;  f3 = 3'b010; end
      beq:   begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'b000; end
      bne:   begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'b001; end
      blt:   begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'b100; end
      bge:   begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'b101; end
      bltu:  begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'b110; end
      bgeu:  begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'b111; end
      add:   begin fmt = FMT_R;  opc = OP_ALU;    f3 = 3'b000; end
      sub:   begin fmt = FMT_R;  opc = OP_ALU;    f3 = 3'b000; f7 = F7_ALT; end
      sll:   begin fmt = FMT_R;  opc = OP_ALU;    f3 = 3'b001; end
      slt:   begin fmt = FMT_R;  opc = OP_ALU;    f3 = 3'b010; end
      xor_:  begin fmt = FMT_R;  opc = OP_ALU;    f3 = 3'b100; end
      srl:   begin fmt = FMT_R;  opc = OP_ALU;    f3 = 3'b101; end
      sra:   begin fmt = FMT_R;  opc = OP_ALU;    f3 = 3'b101; f7 = F7_ALT; end
      or_:   begin fmt = FMT_R;  opc = OP_ALU;    f3 = 3'b110; end
      and_:  begin fmt = FMT_R;  opc = OP_ALU;    f3 = 3'b111; end
      default: fmt = FMT_NONE;
    endcase

    case (fmt)
      FMT_U:  enc_word = {immediate[31:12], rd, opc};
      FMT_J:  enc_word = {immediate[20], immediate[10:1], immediate[11],
                          immediate[19:12], rd, opc};
      FMT_I:  enc_word = {immediate[11:0], rs1, f3, rd, opc};
      FMT_SH: enc_word = {f7, immediate[4:0], rs1, f3, rd, opc};
      FMT_S:  enc_word = {immediate[11:5], rs2, rs1, f3, immediate[4:0], opc};
      FMT_B:  enc_word = {immediate[12], immediate[10:5], rs2, rs1, f3,
                          immediate[4:1], immediate[11], opc};
      FMT_R:  enc_word = {f7, rs2, rs1, f3, rd, opc};
      default: enc_word = '0;
    endcase

`ifdef ENCODER_RANGE_CHECK_EN
    // The immediate must be representable: sign bits above the field must be
    // copies of the field's top bit, and branch/jump offsets must be even.
    case (fmt)
      FMT_I, FMT_S: range_ok = (immediate[31:11] == '0) || (immediate[31:11] == '1);
      FMT_B:  range_ok = ((immediate[31:12] == '0) || (immediate[31:12] == '1)) && !immediate[0];
      FMT_J:  range_ok = ((immediate[31:20] == '0) || (immediate[31:20] == '1)) && !immediate[0];
      FMT_SH: range_ok = (immediate[31:5] == '0);
      FMT_U:  range_ok = (immediate[11:0] == '0);
      default: range_ok = 1'b1;
    endcase
`else
    range_ok = 1'b1;
`endif

    enc_ok = (fmt != FMT_NONE) && range_ok;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state            <= IDLE;
      in_ready         <= 1'b1;
      byte_valid       <= 1'b0;
      out_byte         <= '0;
      byte_idx         <= '0;
      instruction_word <= '0;
      error            <= 1'b0;
      encoded_count    <= '0;
    end else begin
      error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (enc_ok) begin
              instruction_word <= enc_word;
              out_byte         <= enc_word[7:0];
              byte_idx         <= '0;
              byte_valid       <= 1'b1;
              in_ready         <= 1'b0;
              state            <= SEND;
            end else begin
              error <= 1'b1;
            end
          end
        end
        SEND: begin
          if (byte_valid && byte_ready) begin
            if (byte_idx == 2'd3) begin
              encoded_count <= encoded_count + COUNT_WIDTH'(1);
              byte_valid    <= 1'b0;
              in_ready      <= 1'b1;
              state         <= IDLE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              // Preload the next byte so out_byte stays a plain register.
              out_byte <= instruction_word[{byte_idx + 2'd1, 3'b000} +: 8];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed vectors with known
// words, byte-ready flow control, invalid requests, back-to-back requests,
// randomized requests against a reference model, and reset mid-stream.
module tb_instruction_encoder;
  import instruction_encoder_pkg::*;

  localparam int CW = 16;
`ifdef ENCODER_RANGE_CHECK_EN
  localparam bit RANGE_ON = 1'b1;
`else
  localparam bit RANGE_ON = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  operation_t     operation = invalid;
  logic [4:0]     rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0]    immediate = '0;
  logic           byte_valid;
  logic           byte_ready = 1'b0;
  logic [7:0]     out_byte;
  logic [31:0]    instruction_word;
  logic           error;
  logic [CW-1:0]  encoded_count;

  instruction_encoder #(.COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .rd(rd), .rs1(rs1), .rs2(rs2), .immediate(immediate),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .out_byte(out_byte),
    .instruction_word(instruction_word), .error(error), .encoded_count(encoded_count)
  );

  always #5 clock = ~clock;

  int            n_compared   = 0;
  int            n_mismatched = 0;
  logic [CW-1:0] exp_count    = '0;
  logic [31:0]   exp_word     = '0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Reference model: the RV32I field layout written as shifts and masks.
  function automatic void model(input operation_t op, input logic [4:0] d, s1, s2,
                                input logic [31:0] imm, output bit ok, output logic [31:0] word);
    byte         fmt;
    int unsigned opc, f3, f7, r_d, r_s1, r_s2, u;
    longint      simm;
    fmt = "-"; opc = 0; f3 = 0; f7 = 0;
    r_d = d; r_s1 = s1; r_s2 = s2; u = imm;
    simm = longint'($signed(imm));
    case (op)
      lui:   begin fmt = "U"; opc = 'h37; end
      auipc: begin fmt = "U"; opc = 'h17; end
      jal:   begin fmt = "J"; opc = 'h6F; end
      jalr:  begin fmt = "I"; opc = 'h67; end
      lb:    begin fmt = "I"; opc = 'h03; f3 = 0; end
      lh:    begin fmt = "I"; opc = 'h03; f3 = 1; end
      lw:    begin fmt = "I"; opc = 'h03; f3 = 2; end
      lbu:   begin fmt = "I"; opc = 'h03; f3 = 4; end
      lhu:   begin fmt = "I"; opc = 'h03; f3 = 5; end
      addi:  begin fmt = "I"; opc = 'h13; f3 = 0; end
      slti:  begin fmt = "I"; opc = 'h13; f3 = 2; end
      xori:  begin fmt = "I"; opc = 'h13; f3 = 4; end
      ori:   begin fmt = "I"; opc = 'h13; f3 = 6; end
      andi:  begin fmt = "I"; opc = 'h13; f3 = 7; end
      slli:  begin fmt = "H"; opc = 'h13; f3 = 1; end
      srli:  begin fmt = "H"; opc = 'h13; f3 = 5; end
      srai:  begin fmt = "H"; opc = 'h13; f3 = 5; f7 = 'h20; end
      sb:    begin fmt = "S"; opc = 'h23; f3 = 0; end
      sh:    begin fmt = "S"; opc = 'h23; f3 = 1; end
      sw:    begin fmt = "S"; opc = 'h23; f3 = 2; end
      beq:   begin fmt = "B"; opc = 'h63; f3 = 0; end
      bne:   begin fmt = "B"; opc = 'h63; f3 = 1; end
      blt:   begin fmt = "B"; opc = 'h63; f3 = 4; end
      bge:   begin fmt = "B"; opc = 'h63; f3 = 5; end
      bltu:  begin fmt = "B"; opc = 'h63; f3 = 6; end
      bgeu:  begin fmt = "B"; opc = 'h63; f3 = 7; end
      add:   begin fmt = "R"; opc = 'h33; f3 = 0; end
      sub:   begin fmt = "R"; opc = 'h33; f3 = 0; f7 = 'h20; end
      sll:   begin fmt = "R"; opc = 'h33; f3 = 1; end
      slt:   begin fmt = "R"; opc = 'h33; f3 = 2; end
      xor_:  begin fmt = "R"; opc = 'h33; f3 = 4; end
      srl:   begin fmt = "R"; opc = 'h33; f3 = 5; end
      sra:   begin fmt = "R"; opc = 'h33; f3 = 5; f7 = 'h20; end
      or_:   begin fmt = "R"; opc = 'h33; f3 = 6; end
      and_:  begin fmt = "R"; opc = 'h33; f3 = 7; end
      default: fmt = "-";
    endcase
    ok = (fmt != "-");
    if (RANGE_ON) begin
      case (fmt)
        "I", "S": ok = (simm >= -2048) && (simm <= 2047);
        "B":      ok = (simm >= -4096) && (simm <= 4095) && (simm % 2 == 0);
        "J":      ok = (simm >= -(64'sd1 << 20)) && (simm < (64'sd1 << 20)) && (simm % 2 == 0);
        "H":      ok = (u < 32);
        "U":      ok = (u % 4096 == 0);
        default: ;
      endcase
    end
    case (fmt)
      "U": word = (u & 32'hFFFFF000) | (r_d << 7) | opc;
      "J": word = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21) | (((u >> 11) & 1) << 20)
                | (((u >> 12) & 'hFF) << 12) | (r_d << 7) | opc;
      "I": word = ((u & 'hFFF) << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7) | opc;
      "H": word = (f7 << 25) | ((u & 31) << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7) | opc;
      "S": word = (((u >> 5) & 'h7F) << 25) | (r_s2 << 20) | (r_s1 << 15) | (f3 << 12)
                | ((u & 31) << 7) | opc;
      "B": word = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (r_s2 << 20) | (r_s1 << 15)
                | (f3 << 12) | (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7) | opc;
      "R": word = (f7 << 25) | (r_s2 << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7) | opc;
      default: word = '0;
    endcase
  endfunction

  // Waits (bounded) for in_ready, then presents one request for one cycle.
  task automatic send_request(input operation_t op, input logic [4:0] d, s1, s2,
                              input logic [31:0] imm, output bit wait_bad);
    wait_bad = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin wait_bad = 1'b0; break; end
      tick;
    end
    operation = op; rd = d; rs1 = s1; rs2 = s2; immediate = imm;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  // Drains one word from the byte stream. mode 0: ready always high,
  // mode 1: ready pattern 1,0,0,1 repeating, mode 2: random ready.
  task automatic collect_bytes(input int mode, output logic [31:0] got, output int hs,
                               output bit ready_leak, output bit hold_bad, output bit incomplete);
    logic [7:0] held;
    bit         stalled;
    got = '0; hs = 0; ready_leak = 0; hold_bad = 0; incomplete = 1; held = '0; stalled = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      case (mode)
        0: byte_ready = 1'b1;
        1: byte_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: byte_ready = 1'($urandom_range(0, 1));
      endcase
      if (in_ready) ready_leak = 1;
      if (!byte_valid) break;
      if (byte_ready) begin
        got[8*hs +: 8] = out_byte;
        hs++;
        stalled = 0;
      end else begin
        held = out_byte;
        stalled = 1;
      end
      tick;
      if (stalled && out_byte !== held) hold_bad = 1;
      if (hs == 4) begin incomplete = 0; break; end
    end
    byte_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_compared++; if (byte_valid !== 1'b0) begin n_mismatched++; $display("FAIL reset byte_valid: got %b want 0", byte_valid); end
    n_compared++; if (out_byte !== 8'h00) begin n_mismatched++; $display("FAIL reset out_byte: got %h want 00", out_byte); end
    n_compared++; if (instruction_word !== 32'h0) begin n_mismatched++; $display("FAIL reset instruction_word: got %h want 0", instruction_word); end
    n_compared++; if (error !== 1'b0) begin n_mismatched++; $display("FAIL reset error: got %b want 0", error); end
    n_compared++; if (encoded_count !== '0) begin n_mismatched++; $display("FAIL reset encoded_count: got %0d want 0", encoded_count); end
    reset = 1'b0;
    tick;
    exp_count = '0; exp_word = '0;
  endtask

  typedef struct {
    operation_t  op;
    logic [4:0]  d, s1, s2;
    logic [31:0] imm;
    logic [31:0] word;
    bit          ok;
  } vec_t;

  task automatic test_encode_table;
    vec_t        v [7];
    logic [31:0] got;
    int          hs;
    bit          wb, leak, hold, inc;
    v[0] = '{addi, 5'd1, 5'd0, 5'd0, 32'd5,          32'h00500093, 1'b1};
    v[1] = '{add,  5'd3, 5'd1, 5'd2, 32'd0,          32'h002081B3, 1'b1};
    v[2] = '{sub,  5'd3, 5'd1, 5'd2, 32'd0,          32'h402081B3, 1'b1};
    v[3] = '{beq,  5'd0, 5'd1, 5'd2, 32'd8,          32'h00208463, 1'b1};
    v[4] = '{sw,   5'd0, 5'd1, 5'd2, 32'd4,          32'h0020A223, 1'b1};
    v[5] = '{lui,  5'd5, 5'd0, 5'd0, 32'h12345000,   32'h123452B7, 1'b1};
    v[6] = '{beq,  5'd0, 5'd1, 5'd2, 32'd3,          32'h00208163, !RANGE_ON};
    foreach (v[i]) begin
      send_request(v[i].op, v[i].d, v[i].s1, v[i].s2, v[i].imm, wb);
      n_compared++; if (wb) begin n_mismatched++; $display("FAIL table[%0d] in_ready wait: got timeout want ready", i); end
      if (v[i].ok) begin
        n_compared++; if (byte_valid !== 1'b1) begin n_mismatched++; $display("FAIL table[%0d] first byte_valid: got %b want 1", i, byte_valid); end
        n_compared++; if (instruction_word !== v[i].word) begin n_mismatched++; $display("FAIL table[%0d] instruction_word: got %h want %h", i, instruction_word, v[i].word); end
        collect_bytes(0, got, hs, leak, hold, inc);
        n_compared++; if (inc || got !== v[i].word) begin n_mismatched++; $display("FAIL table[%0d] streamed bytes: got %h (%0d bytes) want %h", i, got, hs, v[i].word); end
        exp_count++;
        exp_word = v[i].word;
        n_compared++; if (byte_valid !== 1'b0 || in_ready !== 1'b1) begin n_mismatched++; $display("FAIL table[%0d] end of word: got valid=%b ready=%b want 0/1", i, byte_valid, in_ready); end
        n_compared++; if (encoded_count !== exp_count) begin n_mismatched++; $display("FAIL table[%0d] encoded_count: got %0d want %0d", i, encoded_count, exp_count); end
      end else begin
        n_compared++; if (error !== 1'b1 || byte_valid !== 1'b0) begin n_mismatched++; $display("FAIL table[%0d] range error: got error=%b valid=%b want 1/0", i, error, byte_valid); end
        tick;
        n_compared++; if (error !== 1'b0) begin n_mismatched++; $display("FAIL table[%0d] error pulse width: got %b want 0", i, error); end
      end
    end
  endtask

  task automatic test_flow_control;
    logic [31:0] got;
    int          hs;
    bit          wb, leak, hold, inc;
    send_request(add, 5'd3, 5'd1, 5'd2, 32'd0, wb);
    collect_bytes(1, got, hs, leak, hold, inc);
    exp_count++;
    exp_word = 32'h002081B3;
    n_compared++; if (inc || got !== 32'h002081B3) begin n_mismatched++; $display("FAIL flow bytes: got %h (%0d) want 002081b3", got, hs); end
    n_compared++; if (hold) begin n_mismatched++; $display("FAIL flow out_byte hold: got changed want held"); end
    n_compared++; if (leak) begin n_mismatched++; $display("FAIL flow in_ready during SEND: got 1 want 0"); end
    tick;
    n_compared++; if (byte_valid !== 1'b0 || encoded_count !== exp_count) begin n_mismatched++; $display("FAIL flow extra handshake: got valid=%b count=%0d want 0/%0d", byte_valid, encoded_count, exp_count); end
  endtask

  task automatic test_invalid;
    operation_t bad [2];
    bit         wb;
    bad[0] = invalid;
    bad[1] = operation_t'(6'd63);
    foreach (bad[i]) begin
      send_request(bad[i], 5'd7, 5'd7, 5'd7, 32'h0000_0010, wb);
      n_compared++; if (error !== 1'b1) begin n_mismatched++; $display("FAIL invalid[%0d] error at N+1: got %b want 1", i, error); end
      n_compared++; if (byte_valid !== 1'b0 || in_ready !== 1'b1) begin n_mismatched++; $display("FAIL invalid[%0d] stream idle: got valid=%b ready=%b want 0/1", i, byte_valid, in_ready); end
      n_compared++; if (instruction_word !== exp_word) begin n_mismatched++; $display("FAIL invalid[%0d] instruction_word: got %h want %h", i, instruction_word, exp_word); end
      tick;
      n_compared++; if (error !== 1'b0 || byte_valid !== 1'b0) begin n_mismatched++; $display("FAIL invalid[%0d] after pulse: got error=%b valid=%b want 0/0", i, error, byte_valid); end
      n_compared++; if (encoded_count !== exp_count) begin n_mismatched++; $display("FAIL invalid[%0d] encoded_count: got %0d want %0d", i, encoded_count, exp_count); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] got;
    int          hs;
    bit          leak, hold, inc;
    // Request A is accepted; request B is then held on in_valid throughout A's stream.
    operation = lui; rd = 5'd5; immediate = 32'h12345000; in_valid = 1'b1;
    tick;
    operation = addi; rd = 5'd1; rs1 = 5'd0; immediate = 32'd5;
    collect_bytes(0, got, hs, leak, hold, inc);
    exp_count++;
    n_compared++; if (inc || got !== 32'h123452B7) begin n_mismatched++; $display("FAIL b2b word A: got %h want 123452b7", got); end
    n_compared++; if (leak) begin n_mismatched++; $display("FAIL b2b in_ready during SEND: got 1 want 0"); end
    n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("FAIL b2b ready after last byte: got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    n_compared++; if (byte_valid !== 1'b1 || instruction_word !== 32'h00500093) begin n_mismatched++; $display("FAIL b2b word B accept: got valid=%b word=%h want 1/00500093", byte_valid, instruction_word); end
    collect_bytes(0, got, hs, leak, hold, inc);
    exp_count++;
    exp_word = 32'h00500093;
    n_compared++; if (inc || got !== 32'h00500093 || encoded_count !== exp_count) begin n_mismatched++; $display("FAIL b2b word B: got %h count=%0d want 00500093/%0d", got, encoded_count, exp_count); end
  endtask

  task automatic test_random;
    logic [31:0] got, imm, w;
    int          hs, opv;
    bit          wb, leak, hold, inc, ok;
    operation_t  op;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       opv = $urandom_range(36, 63);
        1:       opv = 0;
        default: opv = $urandom_range(1, 35);
      endcase
      op = operation_t'(6'(opv));
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = $urandom & 32'hFFFFF000;
        2:       imm = 32'($urandom_range(0, 31));
        default: imm = 32'($signed($urandom_range(0, 4000)) - 2000) & ~32'h1;
      endcase
      model(op, 5'($urandom), 5'($urandom), 5'($urandom), imm, ok, w);
      send_request(op, 5'(w >> 7), 5'($urandom), 5'($urandom), imm, wb);
      // The rd bits were randomised by the draw above; recompute with the fields actually driven.
      model(op, rd, rs1, rs2, imm, ok, w);
      n_compared++; if (wb) begin n_mismatched++; $display("FAIL rand[%0d] in_ready wait: got timeout want ready", n); end
      if (ok) begin
        n_compared++; if (byte_valid !== 1'b1 || instruction_word !== w) begin n_mismatched++; $display("FAIL rand[%0d] %s accept: got valid=%b word=%h want 1/%h", n, op.name(), byte_valid, instruction_word, w); end
        collect_bytes(2, got, hs, leak, hold, inc);
        exp_count++;
        exp_word = w;
        n_compared++; if (inc || hold || got !== w) begin n_mismatched++; $display("FAIL rand[%0d] stream: got %h (%0d bytes, hold_bad=%b) want %h", n, got, hs, hold, w); end
        n_compared++; if (encoded_count !== exp_count) begin n_mismatched++; $display("FAIL rand[%0d] encoded_count: got %0d want %0d", n, encoded_count, exp_count); end
      end else begin
        n_compared++; if (error !== 1'b1 || byte_valid !== 1'b0 || instruction_word !== exp_word) begin n_mismatched++; $display("FAIL rand[%0d] reject: got error=%b valid=%b word=%h want 1/0/%h", n, error, byte_valid, instruction_word, exp_word); end
        tick;
        n_compared++; if (error !== 1'b0 || encoded_count !== exp_count) begin n_mismatched++; $display("FAIL rand[%0d] after reject: got error=%b count=%0d want 0/%0d", n, error, encoded_count, exp_count); end
      end
      repeat ($urandom_range(0, 2)) tick;
    end
  endtask

  task automatic test_reset_mid_stream;
    bit wb;
    bit leaked;
    send_request(lui, 5'd5, 5'd0, 5'd0, 32'h12345000, wb);
    byte_ready = 1'b1;
    tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_count = '0;
    exp_word = '0;
    n_compared++; if (byte_valid !== 1'b0 || in_ready !== 1'b1) begin n_mismatched++; $display("FAIL midreset handshake: got valid=%b ready=%b want 0/1", byte_valid, in_ready); end
    n_compared++; if (encoded_count !== exp_count || instruction_word !== exp_word) begin n_mismatched++; $display("FAIL midreset state: got count=%0d word=%h want 0/0", encoded_count, instruction_word); end
    leaked = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (byte_valid !== 1'b0) leaked = 1;
    end
    byte_ready = 1'b0;
    n_compared++; if (leaked) begin n_mismatched++; $display("FAIL midreset extra bytes: got byte_valid high want low"); end
  endtask

  initial begin
    test_reset;
    test_encode_table;
    test_flow_control;
    test_invalid;
    test_back_to_back;
    test_random;
    test_reset_mid_stream;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
